fma_issue_arbiter: RTL and testbench
====================================

FMA_ISSUE_ARBITER -- requirements
Module: fma_issue_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (32 or 64).
REQ-002 SHALL have parameter LATENCY, default 4, fixed FNMADD datapath latency in cycles (1..8).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, result buffer entries (power of 2, >=2).
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports req_valid[1:0] in 2 and req_ready[1:0] out 2, a per-requester valid/ready handshake.
REQ-007 SHALL have ports req_a, req_b, req_c  in  2*WIDTH each  packed operands, requester i in slice i.
REQ-008 SHALL have port req_op  in  2*2  per-requester op: 0 FMADD, 1 FMSUB, 2 FNMADD, 3 FNMSUB.
REQ-009 SHALL have ports dp_valid out 1, dp_a/dp_b/dp_c out WIDTH, dp_op out 2, which issue to the shared datapath.
REQ-010 SHALL have ports dp_res_valid in 1 and dp_res in WIDTH, the datapath result returned LATENCY cycles after dp_valid.
REQ-011 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_id out 1 (requester index) and rsp_res out WIDTH.
REQ-012 SHALL have port err_orphan  out 1, a sticky flag for a result with no matching issue.

Function
REQ-013 Handshake: a request SHALL transfer when req_valid[i] & req_ready[i]; at most one bit of req_ready SHALL be high per cycle.
REQ-014 Arbitration SHALL be round-robin: pointer favours requester ptr; after a grant, ptr becomes the other requester; with no grant, ptr holds.
REQ-015 Credit rule: req_ready SHALL be asserted only when inflight + fifo_count < FIFO_DEPTH, with inflight counted 0..LATENCY+1.
REQ-016 An accepted request SHALL drive dp_valid plus registered operands/op exactly 1 cycle later; dp_valid SHALL be low otherwise.
REQ-017 A LATENCY-deep tag shift register SHALL carry {valid,id} alongside each issue; the tag leaving the shift register SHALL pair with dp_res_valid.
REQ-018 When dp_res_valid and the tag are both valid, dp_res SHALL be written with its id into the result FIFO in that cycle.
REQ-019 When dp_res_valid is high with an invalid tag, the result SHALL be dropped and err_orphan set until reset.
REQ-020 When the tag is valid but dp_res_valid is low, err_orphan SHALL be set and no FIFO write SHALL occur.
REQ-021 rsp_valid SHALL equal FIFO non-empty; a pop SHALL occur on rsp_valid & rsp_ready; results SHALL leave in issue order.
REQ-022 Minimum latency from accept to rsp_valid SHALL be LATENCY+2 cycles.
REQ-023 Full boundary: the credit rule SHALL guarantee that a FIFO write never hits a full FIFO; simultaneous push and pop SHALL be legal at any occupancy.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH, and count SHALL span 0..FIFO_DEPTH.
REQ-025 Sustained throughput SHALL be 1 issue/cycle when rsp_ready stays high and FIFO_DEPTH >= LATENCY+2.

Reset
REQ-026 On rst_n low, all outputs SHALL go to 0 asynchronously: req_ready, dp_valid, dp_a/b/c, dp_op, rsp_valid, rsp_id, rsp_res, err_orphan.
REQ-027 On rst_n low, ptr=0, the tag shift register SHALL be cleared, and FIFO pointers/count SHALL be set to 0.
REQ-028 Reset mid-operation SHALL discard in-flight work; datapath results arriving after reset release SHALL be treated as orphans per REQ-019.

Configuration
REQ-029 With FMA_ARB_PERF_EN defined, the block SHALL add outputs issue_cnt[31:0] (accepted requests) and stall_cnt[31:0] (cycles where any req_valid is high and no grant occurs); both SHALL wrap and reset to 0.
REQ-030 Without FMA_ARB_PERF_EN, those ports and counters SHALL be absent, with no other behavioural change.

Structure
REQ-031 Package fma_ctrl_pkg SHALL hold the op encoding enum (FMADD..FNMSUB), the tag struct {valid,id}, and default WIDTH/LATENCY/FIFO_DEPTH constants.
REQ-032 The result FIFO SHALL be sub-module fma_rsp_fifo (synchronous, registered count, full/empty outputs); the arbiter and tag pipe SHALL stay in the top module.

Verification
REQ-033 Only req0 valid, op=2, LATENCY=4, datapath model returns a value -> single dp_valid 1 cycle after accept, rsp_valid at accept+6, rsp_id=0.
REQ-034 Both requesters valid for 6 cycles, rsp_ready=1 -> grants alternate 0,1,0,1,0,1 and responses return in the same id order.
REQ-035 rsp_ready=0 with req0 always valid, FIFO_DEPTH=4 -> exactly 4 accepts, then req_ready low; one pop -> exactly one further accept.
REQ-036 Force dp_res_valid with no issue -> err_orphan=1 and stays 1; FIFO count unchanged.
REQ-037 Assert rst_n low 2 cycles after 3 accepts -> all outputs 0 immediately, rsp_valid never asserts for those requests, and late dp_res_valid sets err_orphan.
REQ-038 With FMA_ARB_PERF_EN: 10 accepts and 3 contention-free stall cycles -> issue_cnt=10, stall_cnt=3.

Source files
------------

// File: rtl/fma_ctrl_pkg.sv
// Shared types for the FMA issue arbiter: op encoding, in-flight tag, default sizing.
package fma_ctrl_pkg;

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_LATENCY    = 4;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        FMADD  = 2'd0,
        FMSUB  = 2'd1,
        FNMADD = 2'd2,
        FNMSUB = 2'd3
    } fma_op_e;

    typedef struct packed {
        logic valid;
        logic id;
    } fma_tag_t;

endpackage

// File: rtl/fma_rsp_fifo.sv
// Result buffer: synchronous FIFO, registered count, write visible one cycle after push.
// Push is dropped when full, pop is ignored when empty; push and pop may coincide at any level.
module fma_rsp_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_vld_i,
    input  logic [WIDTH-1:0]         push_dat_i,
    input  logic                     pop_rdy_i,
    output logic [WIDTH-1:0]         pop_dat_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      cnt_q, cnt_d;
    logic             push_en, pop_en;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign push_en = push_vld_i && !full_o;
    assign pop_en  = pop_rdy_i && !empty_o;

    // Output is forced to zero while empty so stale entries never leak out.
    assign pop_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        cnt_d = cnt_q;
        if (push_en && !pop_en) cnt_d = cnt_q + 1'b1;
        else if (pop_en && !push_en) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/fma_issue_arbiter.sv
// Two-requester round-robin issue into a fixed-latency FMA datapath; response after >= LATENCY+2 cycles.
// Credit-gated: req_ready only while in-flight plus buffered results fit the FIFO; optional FMA_ARB_PERF_EN counters.
module fma_issue_arbiter
    import fma_ctrl_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int LATENCY    = DEF_LATENCY,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*WIDTH-1:0] req_a,
    input  logic [2*WIDTH-1:0] req_b,
    input  logic [2*WIDTH-1:0] req_c,
    input  logic [3:0]         req_op,
    output logic               dp_valid,
    output logic [WIDTH-1:0]   dp_a,
    output logic [WIDTH-1:0]   dp_b,
    output logic [WIDTH-1:0]   dp_c,
    output logic [1:0]         dp_op,
    input  logic               dp_res_valid,
    input  logic [WIDTH-1:0]   dp_res,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [WIDTH-1:0]   rsp_res,
    output logic               err_orphan
`ifdef FMA_ARB_PERF_EN
    ,
    output logic [31:0]        issue_cnt,
    output logic [31:0]        stall_cnt
`endif
);
    localparam int IW = $clog2(LATENCY+2);
    localparam int CW = $clog2(FIFO_DEPTH)+1;

    logic             ptr_q, ptr_d, sel, accept, credit_ok;
    logic [31:0]      occ;
    logic [IW-1:0]    inflight_q, inflight_d;
    logic             dp_valid_q, dp_id_q;
    logic [WIDTH-1:0] dp_a_q, dp_b_q, dp_c_q, sel_a, sel_b, sel_c;
    fma_op_e          dp_op_q, sel_op;
    fma_tag_t         tag_q [LATENCY];
    fma_tag_t         tail;
    logic             err_orphan_q, err_orphan_d;
    logic             fifo_push, fifo_full, fifo_empty;
    logic [CW-1:0]    fifo_cnt;
    logic [WIDTH:0]   fifo_dat;

    assign tail = tag_q[LATENCY-1];

    always_comb begin
        occ       = 32'(inflight_q) + 32'(fifo_cnt);
        // Gated by rst_n so req_ready drops the instant reset asserts.
        credit_ok = rst_n && (occ < 32'(FIFO_DEPTH));
        sel       = ptr_q;
        if (!req_valid[ptr_q] && req_valid[~ptr_q]) sel = ~ptr_q;
        req_ready      = 2'b00;
        req_ready[sel] = credit_ok;
        accept    = |(req_valid & req_ready);
        ptr_d     = accept ? ~sel : ptr_q;
        sel_a     = sel ? req_a[WIDTH +: WIDTH] : req_a[0 +: WIDTH];
        sel_b     = sel ? req_b[WIDTH +: WIDTH] : req_b[0 +: WIDTH];
        sel_c     = sel ? req_c[WIDTH +: WIDTH] : req_c[0 +: WIDTH];
        sel_op    = fma_op_e'(sel ? req_op[3:2] : req_op[1:0]);
    end

    // Every issue leaves the pipe exactly once (written or dropped), so the tail retires it.
    assign inflight_d   = inflight_q + IW'(accept) - IW'(tail.valid);
    assign fifo_push    = tail.valid && dp_res_valid && !fifo_full;
    assign err_orphan_d = err_orphan_q || (tail.valid != dp_res_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q        <= 1'b0;
            inflight_q   <= '0;
            dp_valid_q   <= 1'b0;
            dp_id_q      <= 1'b0;
            dp_a_q       <= '0;
            dp_b_q       <= '0;
            dp_c_q       <= '0;
            dp_op_q      <= FMADD;
            err_orphan_q <= 1'b0;
            for (int i = 0; i < LATENCY; i++) tag_q[i] <= '0;
        end else begin
            ptr_q        <= ptr_d;
            inflight_q   <= inflight_d;
            dp_valid_q   <= accept;
            err_orphan_q <= err_orphan_d;
            if (accept) begin
                dp_id_q <= sel;
                dp_a_q  <= sel_a;
                dp_b_q  <= sel_b;
                dp_c_q  <= sel_c;
                dp_op_q <= sel_op;
            end
            // The tag enters as the op leaves for the datapath, so the tail aligns with dp_res_valid.
            tag_q[0] <= '{valid: dp_valid_q, id: dp_id_q};
            for (int i = 1; i < LATENCY; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    fma_rsp_fifo #(
        .WIDTH (WIDTH+1),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_vld_i (fifo_push),
        .push_dat_i ({tail.id, dp_res}),
        .pop_rdy_i  (rsp_ready),
        .pop_dat_o  (fifo_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_cnt)
    );

    assign dp_valid   = dp_valid_q;
    assign dp_a       = dp_a_q;
    assign dp_b       = dp_b_q;
    assign dp_c       = dp_c_q;
    assign dp_op      = dp_op_q;
    assign rsp_valid  = !fifo_empty;
    assign rsp_id     = fifo_dat[WIDTH];
    assign rsp_res    = fifo_dat[WIDTH-1:0];
    assign err_orphan = err_orphan_q;

`ifdef FMA_ARB_PERF_EN
    logic [31:0] issue_cnt_q, stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (accept) issue_cnt_q <= issue_cnt_q + 32'd1;
            if ((|req_valid) && !accept) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign issue_cnt = issue_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fma_issue_arbiter.sv
// Directed bench for fma_issue_arbiter: vector table of single transactions plus multi-cycle sequences.
module tb_fma_issue_arbiter;
    localparam int W = 32;
    localparam int L = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [1:0]    req_valid = '0;
    logic [1:0]    req_ready;
    logic [2*W-1:0] req_a = '0, req_b = '0, req_c = '0;
    logic [3:0]    req_op = '0;
    logic          dp_valid;
    logic [W-1:0]  dp_a, dp_b, dp_c;
    logic [1:0]    dp_op;
    logic          dp_res_valid;
    logic [W-1:0]  dp_res;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic          rsp_id;
    logic [W-1:0]  rsp_res;
    logic          err_orphan;
`ifdef FMA_ARB_PERF_EN
    logic [31:0]   issue_cnt, stall_cnt;
`endif

    int total = 0;
    int bad = 0;

    // Datapath stand-in: result = a+b+c+op, returned L cycles after dp_valid.
    logic          mv [L];
    logic [W-1:0]  mr [L];
    logic          drop = 1'b0;
    logic          force_vld = 1'b0;

    always #5 clk = ~clk;

    initial for (int i = 0; i < L; i++) begin mv[i] = 1'b0; mr[i] = '0; end

    always @(posedge clk) begin
        mv[0] <= dp_valid;
        mr[0] <= dp_a + dp_b + dp_c + {30'b0, dp_op};
        for (int i = 1; i < L; i++) begin
            mv[i] <= mv[i-1];
            mr[i] <= mr[i-1];
        end
    end

    assign dp_res_valid = (mv[L-1] & ~drop) | force_vld;
    assign dp_res       = mr[L-1];

    fma_issue_arbiter #(.WIDTH(W), .LATENCY(L), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_c        (req_c),
        .req_op       (req_op),
        .dp_valid     (dp_valid),
        .dp_a         (dp_a),
        .dp_b         (dp_b),
        .dp_c         (dp_c),
        .dp_op        (dp_op),
        .dp_res_valid (dp_res_valid),
        .dp_res       (dp_res),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_res      (rsp_res),
        .err_orphan   (err_orphan)
`ifdef FMA_ARB_PERF_EN
        ,
        .issue_cnt    (issue_cnt),
        .stall_cnt    (stall_cnt)
`endif
    );

    typedef struct {
        int         id;
        logic [1:0] op;
        logic [W-1:0] a, b, c;
        logic [W-1:0] exp_res;
    } vec_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready), 0);
        check({tag, "_dp_valid"}, 64'(dp_valid), 0);
        check({tag, "_dp_a"}, 64'(dp_a), 0);
        check({tag, "_dp_b"}, 64'(dp_b), 0);
        check({tag, "_dp_c"}, 64'(dp_c), 0);
        check({tag, "_dp_op"}, 64'(dp_op), 0);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 0);
        check({tag, "_rsp_id"}, 64'(rsp_id), 0);
        check({tag, "_rsp_res"}, 64'(rsp_res), 0);
        check({tag, "_err_orphan"}, 64'(err_orphan), 0);
    endtask

    // Single isolated request: accept, one-cycle dp issue, response at accept+L+2.
    task automatic run_vec(input vec_t v);
        int  n;
        bit  got;
        @(posedge clk); #1;
        req_valid = '0;
        req_op = '0;
        req_a = '0; req_b = '0; req_c = '0;
        req_valid[v.id] = 1'b1;
        req_op[v.id*2 +: 2] = v.op;
        req_a[v.id*W +: W] = v.a;
        req_b[v.id*W +: W] = v.b;
        req_c[v.id*W +: W] = v.c;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (req_ready[v.id]) got = 1;
        end
        check("vec_accept", 64'(got), 1);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        check("vec_dp_valid", 64'(dp_valid), 1);
        check("vec_dp_a", 64'(dp_a), 64'(v.a));
        check("vec_dp_b", 64'(dp_b), 64'(v.b));
        check("vec_dp_c", 64'(dp_c), 64'(v.c));
        check("vec_dp_op", 64'(dp_op), 64'(v.op));
        n = 1;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            n++;
            if (k == 0) check("vec_dp_single", 64'(dp_valid), 0);
            if (rsp_valid) got = 1;
        end
        check("vec_rsp_latency", 64'(n), 64'(L+2));
        check("vec_rsp_id", 64'(rsp_id), 64'(v.id));
        check("vec_rsp_res", 64'(rsp_res), 64'(v.exp_res));
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t vt [6];
        int   gq[$];
        int   rq[$];
        logic [W-1:0] rres[$];
        int   acc, pops;
        bit   onehot_ok, seen;

        vt[0] = '{id:0, op:2'd2, a:32'd1,          b:32'd2,          c:32'd3,  exp_res:32'd8};
        vt[1] = '{id:1, op:2'd0, a:32'h10,         b:32'h20,         c:32'h30, exp_res:32'h60};
        vt[2] = '{id:0, op:2'd1, a:32'hFFFF_FFFF,  b:32'd1,          c:32'd0,  exp_res:32'd1};
        vt[3] = '{id:1, op:2'd3, a:32'h1000,       b:32'h0200,       c:32'h30, exp_res:32'h1233};
        vt[4] = '{id:0, op:2'd2, a:32'hA5A5_0000,  b:32'h0000_5A5A,  c:32'd1,  exp_res:32'hA5A5_5A5D};
        vt[5] = '{id:1, op:2'd1, a:32'h7FFF_FFFF,  b:32'd1,          c:32'd0,  exp_res:32'h8000_0001};

        #2 rst_n = 1'b0;
        #1 check_all_zero("rst");
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vt[i]);

        // Both requesters contending: grants and responses alternate from requester 0.
        do_reset();
        rsp_ready = 1'b1;
        req_a = {32'h200, 32'h100};
        req_b = '0;
        req_c = '0;
        req_op = {2'd3, 2'd0};
        req_valid = 2'b11;
        onehot_ok = 1;
        for (int k = 0; k < 100 && (gq.size() < 6 || rq.size() < 6); k++) begin
            @(negedge clk);
            if (req_ready == 2'b11) onehot_ok = 0;
            if (rsp_valid) begin
                rq.push_back(int'(rsp_id));
                rres.push_back(rsp_res);
            end
            if ((req_valid & req_ready) != 2'b00) begin
                gq.push_back(req_ready[1] ? 1 : 0);
                if (gq.size() == 6) begin
                    @(posedge clk); #1;
                    req_valid = '0;
                end
            end
        end
        check("rr_ready_onehot", 64'(onehot_ok), 1);
        check("rr_grant_count", 64'(gq.size()), 6);
        check("rr_rsp_count", 64'(rq.size()), 6);
        for (int i = 0; i < gq.size(); i++) check("rr_grant_order", 64'(gq[i]), 64'(i % 2));
        for (int i = 0; i < rq.size(); i++) begin
            check("rr_rsp_order", 64'(rq[i]), 64'(i % 2));
            check("rr_rsp_res", 64'(rres[i]), (i % 2) ? 64'h203 : 64'h100);
        end

        // Credit limit with the consumer stalled.
        do_reset();
        rsp_ready = 1'b0;
        req_op = '0;
        req_valid = 2'b01;
        acc = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_valid[0] && req_ready[0]) acc++;
        end
        check("credit_accepts", 64'(acc), 4);
        check("credit_ready_low", 64'(req_ready), 0);
        check("credit_rsp_valid", 64'(rsp_valid), 1);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (req_valid[0] && req_ready[0]) acc++;
        end
        check("credit_one_more", 64'(acc), 1);
        @(posedge clk); #1;
        req_valid = '0;
        rsp_ready = 1'b1;
        pops = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) pops++;
        end
        check("credit_drain_pops", 64'(pops), 4);
        check("credit_drained", 64'(rsp_valid), 0);

        // Result with no matching issue.
        check("orphan_clear", 64'(err_orphan), 0);
        @(posedge clk); #1;
        force_vld = 1'b1;
        @(posedge clk); #1;
        force_vld = 1'b0;
        @(negedge clk);
        check("orphan_set", 64'(err_orphan), 1);
        check("orphan_no_push", 64'(rsp_valid), 0);
        repeat (5) @(negedge clk);
        check("orphan_sticky", 64'(err_orphan), 1);

        // Issue whose result never comes back.
        do_reset();
        check("missing_clear", 64'(err_orphan), 0);
        drop = 1'b1;
        req_valid = 2'b01;
        @(posedge clk); #1;
        req_valid = '0;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        check("missing_set", 64'(err_orphan), 1);
        check("missing_no_rsp", 64'(seen), 0);
        drop = 1'b0;

        // Reset with work in flight; late results become orphans.
        do_reset();
        rsp_ready = 1'b1;
        req_valid = 2'b01;
        acc = 0;
        for (int k = 0; k < 20 && acc < 3; k++) begin
            @(negedge clk);
            if (req_valid[0] && req_ready[0]) acc++;
        end
        @(posedge clk); #1;
        req_valid = '0;
        check("midrst_accepts", 64'(acc), 3);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1 check_all_zero("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        check("midrst_no_rsp", 64'(seen), 0);
        check("midrst_orphan", 64'(err_orphan), 1);

`ifdef FMA_ARB_PERF_EN
        // 4 credit-limited accepts + 3 stall cycles, then 6 isolated accepts.
        do_reset();
        rsp_ready = 1'b0;
        req_valid = 2'b01;
        repeat (7) @(posedge clk);
        #1;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (12) @(posedge clk);
        for (int i = 0; i < 6; i++) run_vec(vt[i]);
        @(negedge clk);
        check("perf_issue_cnt", 64'(issue_cnt), 10);
        check("perf_stall_cnt", 64'(stall_cnt), 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation ran past its time limit");
        $fatal(1, "timeout");
    end

endmodule
